// File: rtl/hls_call_pkg.sv
// hls_call_pkg: shared state encoding and default sizes for the kernel call driver
package hls_call_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} call_state_t;
  localparam int W_DEF = 64;
  localparam int NARGS_DEF = 7;
endpackage

// File: rtl/hls_rise_detect.sv
// hls_rise_detect: registered previous level plus rising-edge strobe
module hls_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev_q;
  always_ff @(posedge clk) prev_q <= rst ? 1'b0 : d;
  assign rise = d && !prev_q;
endmodule

// File: rtl/hls_call_driver.sv
// hls_call_driver: launches one kernel call per argument bundle and returns result plus latency
module hls_call_driver
  import hls_call_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int NARGS   = NARGS_DEF,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NARGS-1:0][W-1:0]    in_args,
  output logic                       k_r_enable,
  output logic [NARGS-1:0][W-1:0]    k_args,
  input  logic                       k_w_enable,
  input  logic [W-1:0]               k_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_result,
  output logic [CNT_W-1:0]           out_cycles,
  output logic                       out_timeout,
  output logic                       busy
);
  call_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic rise;
  hls_rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (k_w_enable),
    .rise (rise)
  );
  assign in_ready = state_q == IDLE;
  assign busy     = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_r_enable  <= 1'b0;
      k_args      <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_cycles  <= '0;
      out_timeout <= 1'b0;
      cnt_q       <= '0;
    end else begin
      k_r_enable <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          k_args     <= in_args;
          k_r_enable <= 1'b1;
          state_q    <= LAUNCH;
        end
        LAUNCH: begin
          cnt_q   <= CNT_W'(1);
          state_q <= WAIT;
        end
        WAIT: if (rise || cnt_q == CNT_W'(TIMEOUT)) begin
          out_result  <= rise ? k_result : '0;
          out_cycles  <= cnt_q;
          out_timeout <= !rise;
          out_valid   <= 1'b1;
          state_q     <= DONE;
        end else cnt_q <= cnt_q + CNT_W'(1);
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
